// File: rtl/ftdi_emu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_emu_pkg
// Purpose  : Shared widths and state encoding for the FT232H 245-FIFO emulator.
// Revision : 1.0
// ============================================================================
package ftdi_emu_pkg;

    localparam int ADBUS_W = 8;
    localparam int GAP_W   = 16;

    typedef enum logic [1:0] {
        RXS_EMPTY = 2'd0,
        RXS_READY = 2'd1,
        RXS_HOLD  = 2'd2
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/ftdi_emu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_emu_sync_fifo
// Purpose  : Single-clock first-word-fall-through byte FIFO of depth 2^EA.
// Revision : 1.0
// ============================================================================
module ftdi_emu_sync_fifo
    import ftdi_emu_pkg::*;
#(
    parameter int EA = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [ADBUS_W-1:0] din_i,
    input  logic               pop_i,
    output logic [ADBUS_W-1:0] dout_o,
    output logic [EA:0]        count_o,
    output logic [EA:0]        count_next_o
);

    localparam int             DEPTH    = 1 << EA;
    localparam logic [EA:0]    FULL_CNT = {1'b1, {EA{1'b0}}};

    logic [ADBUS_W-1:0] mem_q [DEPTH];
    logic [EA-1:0]      wr_ptr_q;
    logic [EA-1:0]      rd_ptr_q;
    logic [EA:0]        count_q;
    logic [EA:0]        count_d;
    logic               do_push;
    logic               do_pop;

    assign do_push = push_i & (count_q != FULL_CNT);
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule
`default_nettype wire

// File: rtl/ftdi_245fifo_chip_emu.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_245fifo_chip_emu
// Purpose  : Chip-side emulation of the FT232H 245 synchronous FIFO interface.
// Revision : 1.0
// ============================================================================
module ftdi_245fifo_chip_emu
    import ftdi_emu_pkg::*;
#(
    parameter int RX_EA    = 10,
    parameter int TX_EA    = 10,
    parameter int TX_BURST = 512,
    parameter int TX_GAP   = 8,
    parameter int RX_GAP   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               h2d_tvalid,
    output logic               h2d_tready,
    input  logic [ADBUS_W-1:0] h2d_tdata,
    output logic               d2h_tvalid,
    input  logic               d2h_tready,
    output logic [ADBUS_W-1:0] d2h_tdata,
    output logic               ftdi_rxf_n,
    output logic               ftdi_txe_n,
    input  logic               ftdi_oe_n,
    input  logic               ftdi_rd_n,
    input  logic               ftdi_wr_n,
    inout  wire  [ADBUS_W-1:0] ftdi_data,
    output logic               proto_err
);

    localparam logic [RX_EA:0] RX_FULL = {1'b1, {RX_EA{1'b0}}};
    localparam logic [TX_EA:0] TX_FULL = {1'b1, {TX_EA{1'b0}}};

    logic [ADBUS_W-1:0] rx_head;
    logic [ADBUS_W-1:0] rx_bus;
    logic [ADBUS_W-1:0] last_q;
    logic [RX_EA:0]     rx_cnt;
    logic [RX_EA:0]     rx_cnt_next;
    logic               rx_push;
    logic               rx_pop;
    rx_state_e          rx_state_q;
    rx_state_e          rx_state_d;
    logic [GAP_W-1:0]   rx_gap_q;
    logic [GAP_W-1:0]   rx_gap_d;

    logic [TX_EA:0]     tx_cnt;
    logic [TX_EA:0]     tx_cnt_next;
    logic               tx_wr;
    logic               tx_pop;
    logic               txe_n_q;
    logic               txe_n_d;
    logic [GAP_W-1:0]   burst_q;
    logic [GAP_W-1:0]   burst_d;
    logic [GAP_W-1:0]   tx_gap_q;
    logic [GAP_W-1:0]   tx_gap_d;
    logic               proto_q;
    logic               proto_d;

    ftdi_emu_sync_fifo #(.EA(RX_EA)) u_rx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (rx_push),
        .din_i        (h2d_tdata),
        .pop_i        (rx_pop),
        .dout_o       (rx_head),
        .count_o      (rx_cnt),
        .count_next_o (rx_cnt_next)
    );

    ftdi_emu_sync_fifo #(.EA(TX_EA)) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (tx_wr),
        .din_i        (ftdi_data),
        .pop_i        (tx_pop),
        .dout_o       (d2h_tdata),
        .count_o      (tx_cnt),
        .count_next_o (tx_cnt_next)
    );

    assign h2d_tready = ~rst & (rx_cnt != RX_FULL);
    assign rx_push    = h2d_tvalid & h2d_tready;
    assign rx_pop     = ~ftdi_rd_n & ~ftdi_oe_n & (rx_state_q == RXS_READY);
    assign ftdi_rxf_n = (rx_state_q != RXS_READY);

    // An empty buffer keeps presenting the byte most recently handed out.
    assign rx_bus    = (rx_cnt == '0) ? last_q : rx_head;
    assign ftdi_data = ftdi_oe_n ? {ADBUS_W{1'bz}} : rx_bus;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_gap_d   = rx_gap_q;
        case (rx_state_q)
            RXS_READY: begin
                if (rx_cnt_next == '0) begin
                    if (RX_GAP > 0) begin
                        rx_state_d = RXS_HOLD;
                        rx_gap_d   = GAP_W'(RX_GAP);
                    end else begin
                        rx_state_d = RXS_EMPTY;
                    end
                end
            end
            RXS_HOLD: begin
                if (rx_gap_q > GAP_W'(1)) begin
                    rx_gap_d = rx_gap_q - 1'b1;
                end else begin
                    rx_gap_d   = '0;
                    rx_state_d = (rx_cnt_next != '0) ? RXS_READY : RXS_EMPTY;
                end
            end
            default: begin
                if (rx_cnt_next != '0) begin
                    rx_state_d = RXS_READY;
                end
            end
        endcase
    end

    assign tx_wr      = ~ftdi_wr_n & ~txe_n_q;
    assign tx_pop     = d2h_tvalid & d2h_tready;
    assign d2h_tvalid = (tx_cnt != '0);
    assign ftdi_txe_n = txe_n_q;
    assign proto_err  = proto_q;

    always_comb begin
        burst_d  = burst_q;
        tx_gap_d = (tx_gap_q != '0) ? tx_gap_q - 1'b1 : '0;
        if (tx_wr && (TX_BURST > 0)) begin
            if (burst_q == GAP_W'(TX_BURST - 1)) begin
                burst_d  = '0;
                tx_gap_d = GAP_W'(TX_GAP);
            end else begin
                burst_d = burst_q + 1'b1;
            end
        end
        // Closing on the last free slot is deliberately pessimistic about a same-cycle pop.
        txe_n_d = (tx_cnt_next == TX_FULL) || (tx_gap_d != '0)
                  || (tx_wr && (tx_cnt == TX_FULL - 1'b1));
        proto_d = proto_q | (~ftdi_oe_n & ~ftdi_wr_n) | (~ftdi_rd_n & ftdi_oe_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RXS_EMPTY;
            rx_gap_q   <= '0;
            last_q     <= '0;
            txe_n_q    <= 1'b1;
            burst_q    <= '0;
            tx_gap_q   <= '0;
            proto_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_gap_q   <= rx_gap_d;
            txe_n_q    <= txe_n_d;
            burst_q    <= burst_d;
            tx_gap_q   <= tx_gap_d;
            proto_q    <= proto_d;
            if (rx_pop) begin
                last_q <= rx_head;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ftdi_245fifo_chip_emu.md
Name: ftdi_245fifo_chip_emu

Overview:
- Synthesizable emulator of the FT232H chip side of the 245 synchronous-FIFO interface. It answers an FPGA-side 245fifo controller on the same ftdi_* pins.
- A host-side byte stream enters an internal RX buffer, which the FPGA reads through RXF#/OE#/RD#. Bytes the FPGA writes through TXE#/WR# land in a TX buffer and leave on a host-side stream.
- Used in loopback benches and in on-chip self-test builds, where there is no real FTDI device.

Parameters:
- RX_EA, 10: RX buffer (host->FPGA) depth is 2^RX_EA bytes.
- TX_EA, 10: TX buffer (FPGA->host) depth is 2^TX_EA bytes.
- TX_BURST, 512: bytes accepted before a forced TXE# gap, modelling the USB packet boundary. 0 disables the gap.
- TX_GAP, 8: cycles TXE# is held high after each TX burst.
- RX_GAP, 4: cycles RXF# is held high after the RX buffer drains, before it may fall again.

Ports:
- clk  in  1  emulated CLKOUT; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- h2d_tvalid  in  1  host->FPGA byte valid.
- h2d_tready  out  1  RX buffer not full.
- h2d_tdata  in  8  host->FPGA byte.
- d2h_tvalid  out  1  TX buffer not empty.
- d2h_tready  in  1  host accepts the byte.
- d2h_tdata  out  8  head of the TX buffer.
- ftdi_rxf_n  out  1  RXF#, low = data available.
- ftdi_txe_n  out  1  TXE#, low = space available.
- ftdi_oe_n  in  1  OE# from the FPGA.
- ftdi_rd_n  in  1  RD# from the FPGA.
- ftdi_wr_n  in  1  WR# from the FPGA.
- ftdi_data  inout  8  ADBUS; driven only while ftdi_oe_n=0.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
Reset values:
- rxf_n=1, txe_n=1, h2d_tready=0 during rst, d2h_tvalid=0, proto_err=0.
- Both buffers are emptied and all gap counters cleared.
- txe_n falls on the first cycle after rst deasserts. Reset mid-transfer discards all buffered bytes, with no partial state.

RX buffer (host->FPGA):
- First-word-fall-through.
- Push on h2d_tvalid & h2d_tready.
- ftdi_data = RX head whenever oe_n=0; otherwise high-Z. When the buffer is empty the driven value is the last popped byte.
- Pop at the edge where rd_n=0 & oe_n=0 & rxf_n=0. The next byte appears on ftdi_data in the following cycle.
- rxf_n is registered. It is computed from the post-update count:
  - Goes high the cycle after the last byte is popped.
  - Then stays high for at least RX_GAP cycles.
  - Falls the first cycle after that at which count>0.
- Simultaneous push and pop: the count is unchanged. A push into an empty buffer makes rxf_n fall after at least 1 cycle.
- A pop attempt while rxf_n=1 is ignored and is not an error.

TX buffer (FPGA->host):
- Write at the edge where wr_n=0 & txe_n=0; ftdi_data is sampled.
- The write counter counts accepted bytes. On reaching TX_BURST it resets to 0 and txe_n is forced high for TX_GAP cycles.
- txe_n is registered. It is high if:
  - the buffer is full after the update, or
  - a gap is active, or
  - the buffer has 1 free slot and a write occurs this cycle.
- wr_n=0 while txe_n=1 is ignored (no write) and is not an error.
- d2h is FWFT; pop on d2h_tvalid & d2h_tready. A simultaneous write and pop keeps the count.

proto_err is set and held until rst when either holds at an edge:
- oe_n=0 & wr_n=0, i.e. FPGA writing while the chip drives the bus.
- rd_n=0 & oe_n=1, i.e. read without output enable.

Pointer and count rules:
- Pointers are EA bits and wrap naturally. Counts are EA+1 bits.
- Full: count = 2^EA. Empty: count = 0.

Gap counters are independent 16-bit down-counters.

Decomposition:
- Shared package ftdi_emu_pkg holds the ADBUS width constant (8) and a gap-counter width constant (16).
- One sub-module, ftdi_emu_sync_fifo (single-clock FWFT FIFO, parameterised by EA), is instantiated twice. The top holds the gap FSMs, tristate and checker.

Test Plan:
- Single RX byte: push 0x5A via h2d, then drive oe_n=0 at cycle N and rd_n=0 at N+1. Required: ftdi_data=0x5A at N, rxf_n=1 the cycle after the pop, and rxf_n stays high for ≥4 cycles.
- RX full: push 1024 bytes 0x00..0xFF repeating without reading. Required: h2d_tready=0 after the 1024th push. One FPGA read then brings h2d_tready back to 1.
- TX burst gap, TX_BURST=4, TX_GAP=8: FPGA streams wr_n=0 with 0x10..0x17. Required:
  - Exactly 4 bytes are accepted, then txe_n=1 for 8 cycles.
  - The remaining bytes are accepted afterwards.
  - d2h emits 0x10..0x17 in order.
- TX backpressure: d2h_tready=0 while 1024 bytes are written. Required: txe_n=1 from the full point, extra wr_n=0 strobes are dropped, and proto_err stays 0.
- Protocol violation: oe_n=0 & wr_n=0 for one cycle. Required: proto_err=1 the next cycle and held until rst.
- Reset mid-read: 3 bytes in the RX buffer, assert rst during the rd_n=0 burst. Required: after reset rxf_n=1, d2h_tvalid=0, and no stale byte reappears.
